// File: rtl/feeder_pkg.sv
// Shared definitions for the RTC display feeder: sweep FSM states, RTC register map and defaults.
package feeder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    PUSH = 2'd2,
    NEXT = 2'd3
  } feeder_state_e;

  localparam int FEEDER_N_REGS  = 9;
  localparam int FEEDER_TIMEOUT = 255;

  // Entry i is read into display slot i; entries past the populated range are unused.
  localparam logic [15:0][7:0] ADDR_TABLE = {
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h43, 8'h42, 8'h41,
    8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21
  };

  function automatic logic is_bcd(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/feeder_timeout.sv
// Saturating wait counter for bus masters; expired stays high once the count reaches MAX.
module feeder_timeout #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == MAX_C);

endmodule

// File: rtl/rtc_display_feeder.sv
// Once per frame (V_ON falling edge) reads the RTC registers and strobes each byte to the digit renderer.
// Build option FEEDER_BCD_CHECK_EN: acknowledged bytes that are not valid BCD are dropped and flag the sweep.
module rtc_display_feeder
  import feeder_pkg::*;
#(
  parameter int N_REGS  = FEEDER_N_REGS,
  parameter int TIMEOUT = FEEDER_TIMEOUT
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic       V_ON,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic       rd_ack,
  input  logic [7:0] rd_data,
  output logic [7:0] DIR_DATO,
  output logic [3:0] POSICION,
  output logic       RD,
  output logic       busy,
  output logic       err
);

  localparam logic [3:0] LAST_IDX = 4'(N_REGS - 1);

  feeder_state_e state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    dato_q, dato_d;
  logic [3:0]    pos_q, pos_d;
  logic          rd_q, rd_d;
  logic          sweep_err_q, sweep_err_d;
  logic          err_q, err_d;
  logic          v_on_q;
  logic          trigger, expired, fwd_ok;

  assign trigger = v_on_q & ~V_ON;

`ifdef FEEDER_BCD_CHECK_EN
  assign fwd_ok = is_bcd(rd_data);
`else
  assign fwd_ok = 1'b1;
`endif

  feeder_timeout #(
    .MAX(TIMEOUT)
  ) u_timeout (
    .clk    (reloj),
    .rst    (resetM),
    .clr    (state_q != REQ),
    .en     (state_q == REQ),
    .expired(expired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    dato_d      = dato_q;
    pos_d       = pos_q;
    rd_d        = 1'b0;
    sweep_err_d = sweep_err_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          idx_d       = 4'd0;
          sweep_err_d = 1'b0;
          addr_d      = ADDR_TABLE[0];
          state_d     = REQ;
        end
      end
      REQ: begin
        // An ack in the same cycle as expiry still wins: the byte is already valid.
        if (rd_ack) begin
          if (fwd_ok) begin
            dato_d  = rd_data;
            pos_d   = idx_q;
            rd_d    = 1'b1;
            state_d = PUSH;
          end else begin
            sweep_err_d = 1'b1;
            state_d     = NEXT;
          end
        end else if (expired) begin
          sweep_err_d = 1'b1;
          state_d     = NEXT;
        end
      end
      PUSH: begin
        state_d = NEXT;
      end
      NEXT: begin
        if (idx_q == LAST_IDX) begin
          err_d   = sweep_err_q;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          addr_d  = ADDR_TABLE[idx_q + 4'd1];
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      addr_q      <= 8'd0;
      dato_q      <= 8'd0;
      pos_q       <= 4'd0;
      rd_q        <= 1'b0;
      sweep_err_q <= 1'b0;
      err_q       <= 1'b0;
      v_on_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      dato_q      <= dato_d;
      pos_q       <= pos_d;
      rd_q        <= rd_d;
      sweep_err_q <= sweep_err_d;
      err_q       <= err_d;
      v_on_q      <= V_ON;
    end
  end

  assign rd_req   = (state_q == REQ);
  assign rd_addr  = addr_q;
  assign DIR_DATO = dato_q;
  assign POSICION = pos_q;
  assign RD       = rd_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_rtc_display_feeder.sv
// Randomized bench for rtc_display_feeder: a behavioural RTC plus a per-sweep timeline model.
module tb_rtc_display_feeder;

  localparam int N_REGS  = 9;
  localparam int TIMEOUT = 255;
  localparam int BUDGET  = N_REGS * (TIMEOUT + 3) + 20;
`ifdef FEEDER_BCD_CHECK_EN
  localparam bit BCD_CHK = 1'b1;
`else
  localparam bit BCD_CHK = 1'b0;
`endif

  typedef struct { int cyc; int pos; int dat; } rd_ev_t;
  typedef struct { int start; int len; int addr; } req_ev_t;

  logic       reloj, resetM, V_ON, rd_ack;
  logic [7:0] rd_data;
  logic       rd_req, RD, busy, err;
  logic [7:0] rd_addr, DIR_DATO;
  logic [3:0] POSICION;

  rtc_display_feeder #(.N_REGS(N_REGS), .TIMEOUT(TIMEOUT)) dut (
    .reloj(reloj), .resetM(resetM), .V_ON(V_ON),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .DIR_DATO(DIR_DATO), .POSICION(POSICION), .RD(RD), .busy(busy), .err(err)
  );

  initial begin
    reloj = 1'b0;
    forever #5 reloj = ~reloj;
  end

  int ref_addr [N_REGS] = '{'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h41, 'h42, 'h43};
  int lat_r [N_REGS];
  int dat_r [N_REGS];
  int checks, errors, cyc;
  bit spur_en, req_prev;
  int req_start, req_addr, wcnt, addr_unstable;
  rd_ev_t  act_rd[$], exp_rd[$];
  req_ev_t act_req[$], exp_req[$];

  function automatic bit ref_bcd(int d);
    return ((d / 16) < 10) && ((d % 16) < 10);
  endfunction

  // One clock cycle: observe the DUT at the falling edge, then act as the RTC for this cycle.
  task automatic tick();
    int idx;
    @(negedge reloj);
    cyc++;
    if (RD === 1'b1) act_rd.push_back('{cyc, int'(POSICION), int'(DIR_DATO)});
    if (rd_req === 1'b1) begin
      if (!req_prev) begin
        req_start = cyc;
        req_addr  = int'(rd_addr);
        wcnt      = 0;
      end else if (int'(rd_addr) != req_addr) begin
        addr_unstable++;
      end
    end else if (req_prev) begin
      act_req.push_back('{req_start, cyc - req_start, req_addr});
    end
    req_prev = (rd_req === 1'b1);
    rd_ack  = 1'b0;
    rd_data = 8'($urandom);
    if (req_prev) begin
      idx = -1;
      for (int i = 0; i < N_REGS; i++) if (ref_addr[i] == req_addr) idx = i;
      if (idx >= 0 && lat_r[idx] == wcnt) begin
        rd_ack  = 1'b1;
        rd_data = 8'(dat_r[idx]);
      end
      wcnt++;
    end else if (spur_en) begin
      rd_ack = 1'($urandom_range(0, 1));
    end
  endtask

  // Expected timeline: requests start at t+1, an ack at cycle a gives RD at a+1 and the next request at a+3.
  task automatic build_exp(input int t, output int t_end, output int e_err);
    int s, a;
    s = t + 1;
    e_err = 0;
    exp_rd.delete();
    exp_req.delete();
    for (int i = 0; i < N_REGS; i++) begin
      if (lat_r[i] < 0) begin
        exp_req.push_back('{s, TIMEOUT + 1, ref_addr[i]});
        e_err = 1;
        s = s + TIMEOUT + 2;
      end else begin
        a = s + lat_r[i];
        exp_req.push_back('{s, lat_r[i] + 1, ref_addr[i]});
        if (BCD_CHK && !ref_bcd(dat_r[i])) begin
          e_err = 1;
          s = a + 2;
        end else begin
          exp_rd.push_back('{a + 1, i, dat_r[i]});
          s = a + 3;
        end
      end
    end
    t_end = s;
  endtask

  task automatic drive_sweep(input int retrig_k, output bit done, output int t_obs,
                             output int err_start, output int t_trig);
    act_rd.delete();
    act_req.delete();
    addr_unstable = 0;
    done = 1'b0;
    t_obs = -1;
    err_start = -1;
    V_ON = 1'b1;
    tick();
    V_ON = 1'b0;
    t_trig = cyc;
    for (int k = 0; k < BUDGET; k++) begin
      tick();
      if (k == 0) err_start = int'(err);
      if (k == retrig_k) V_ON = 1'b1;
      else if (k == retrig_k + 1) V_ON = 1'b0;
      if (k > 0 && busy === 1'b0) begin
        done = 1'b1;
        t_obs = cyc;
        break;
      end
    end
  endtask

  function automatic int rd_diff();
    int n;
    n = (act_rd.size() < exp_rd.size()) ? act_rd.size() : exp_rd.size();
    for (int i = 0; i < n; i++)
      if (act_rd[i].cyc != exp_rd[i].cyc || act_rd[i].pos != exp_rd[i].pos ||
          act_rd[i].dat != exp_rd[i].dat) return i;
    return (act_rd.size() != exp_rd.size()) ? n : -1;
  endfunction

  function automatic int req_diff();
    int n;
    n = (act_req.size() < exp_req.size()) ? act_req.size() : exp_req.size();
    for (int i = 0; i < n; i++)
      if (act_req[i].start != exp_req[i].start || act_req[i].len != exp_req[i].len ||
          act_req[i].addr != exp_req[i].addr) return i;
    return (act_req.size() != exp_req.size()) ? n : -1;
  endfunction

  function automatic string rd_str(int d);
    string a, e;
    a = "none";
    e = "none";
    if (d < act_rd.size()) a = $sformatf("cyc%0d pos%0d dat%02h", act_rd[d].cyc, act_rd[d].pos, act_rd[d].dat);
    if (d < exp_rd.size()) e = $sformatf("cyc%0d pos%0d dat%02h", exp_rd[d].cyc, exp_rd[d].pos, exp_rd[d].dat);
    return $sformatf("strobe %0d got %s (n=%0d) need %s (n=%0d)", d, a, act_rd.size(), e, exp_rd.size());
  endfunction

  function automatic string req_str(int d);
    string a, e;
    a = "none";
    e = "none";
    if (d < act_req.size()) a = $sformatf("start%0d len%0d addr%02h", act_req[d].start, act_req[d].len, act_req[d].addr);
    if (d < exp_req.size()) e = $sformatf("start%0d len%0d addr%02h", exp_req[d].start, exp_req[d].len, exp_req[d].addr);
    return $sformatf("req %0d got %s (n=%0d) need %s (n=%0d)", d, a, act_req.size(), e, exp_req.size());
  endfunction

  task automatic test_reset();
    int act;
    resetM = 1'b1; V_ON = 1'b1; rd_ack = 1'b0; rd_data = 8'd0; spur_en = 1'b0;
    repeat (3) tick();
    checks++;
    if ({rd_req, rd_addr, DIR_DATO, POSICION, RD, busy, err} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got req%b addr%h dat%h pos%h rd%b busy%b err%b, need all 0",
               rd_req, rd_addr, DIR_DATO, POSICION, RD, busy, err);
    end
    resetM = 1'b0;
    V_ON = 1'b0;
    act = 0;
    repeat (5) begin
      tick();
      if (rd_req !== 1'b0 || busy !== 1'b0) act++;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL reset_no_trigger: got %0d active cycles, need 0", act);
    end
  endtask

  task automatic test_single_sweep();
    bit done; int t_obs, es, t, t_end, e_err, d;
    spur_en = 1'b0;
    for (int i = 0; i < N_REGS; i++) begin lat_r[i] = 0; dat_r[i] = ref_addr[i] + 1; end
    drive_sweep(-1, done, t_obs, es, t);
    build_exp(t, t_end, e_err);
    checks++; if (!done) begin errors++; $display("FAIL single_done: got no return to idle, need idle"); end
    checks++; if (t_obs != t_end) begin errors++; $display("FAIL single_end: got idle at %0d, need %0d", t_obs, t_end); end
    d = rd_diff();
    checks++; if (d >= 0) begin errors++; $display("FAIL single_rd: %s", rd_str(d)); end
    d = req_diff();
    checks++; if (d >= 0) begin errors++; $display("FAIL single_req: %s", req_str(d)); end
    checks++; if (err !== 1'(e_err)) begin errors++; $display("FAIL single_err: got %b, need %0d", err, e_err); end
  endtask

  task automatic test_wait_states();
    bit done; int t_obs, es, t, t_end, e_err, d;
    spur_en = 1'b1;
    for (int i = 0; i < N_REGS; i++) begin lat_r[i] = 5; dat_r[i] = int'($urandom_range(0, 255)); end
    drive_sweep(-1, done, t_obs, es, t);
    build_exp(t, t_end, e_err);
    checks++; if (t_obs != t_end) begin errors++; $display("FAIL wait_end: got idle at %0d, need %0d", t_obs, t_end); end
    d = rd_diff();
    checks++; if (d >= 0) begin errors++; $display("FAIL wait_rd: %s", rd_str(d)); end
    d = req_diff();
    checks++; if (d >= 0) begin errors++; $display("FAIL wait_req: %s", req_str(d)); end
    checks++; if (addr_unstable != 0) begin errors++; $display("FAIL wait_addr_stable: got %0d changes, need 0", addr_unstable); end
    checks++; if (err !== 1'(e_err)) begin errors++; $display("FAIL wait_err: got %b, need %0d", err, e_err); end
  endtask

  task automatic test_timeout();
    bit done; int t_obs, es, t, t_end, e_err, d;
    spur_en = 1'b1;
    for (int i = 0; i < N_REGS; i++) begin lat_r[i] = int'($urandom_range(0, 3)); dat_r[i] = 8'h11 * (i % 10); end
    lat_r[2] = -1;
    drive_sweep(-1, done, t_obs, es, t);
    build_exp(t, t_end, e_err);
    checks++; if (t_obs != t_end) begin errors++; $display("FAIL timeout_end: got idle at %0d, need %0d", t_obs, t_end); end
    checks++;
    if (act_req.size() < 3 || act_req[2].len != TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_req_len: got %0d cycles, need %0d", (act_req.size() < 3) ? -1 : act_req[2].len, TIMEOUT + 1);
    end
    d = rd_diff();
    checks++; if (d >= 0) begin errors++; $display("FAIL timeout_rd: %s", rd_str(d)); end
    d = req_diff();
    checks++; if (d >= 0) begin errors++; $display("FAIL timeout_req: %s", req_str(d)); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b, need 1", err); end
    lat_r[2] = 1;
    drive_sweep(-1, done, t_obs, es, t);
    build_exp(t, t_end, e_err);
    checks++; if (es != 1) begin errors++; $display("FAIL timeout_err_hold: got %0d during next sweep, need 1", es); end
    d = rd_diff();
    checks++; if (d >= 0) begin errors++; $display("FAIL clean_rd: %s", rd_str(d)); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clean_err: got %b, need 0", err); end
  endtask

  task automatic test_retrigger();
    bit done; int t_obs, es, t, t_end, e_err, d;
    spur_en = 1'b0;
    for (int i = 0; i < N_REGS; i++) begin lat_r[i] = int'($urandom_range(0, 4)); dat_r[i] = 8'h09 + i; end
    drive_sweep(int'($urandom_range(5, 15)), done, t_obs, es, t);
    build_exp(t, t_end, e_err);
    d = req_diff();
    checks++; if (d >= 0) begin errors++; $display("FAIL retrig_req: %s", req_str(d)); end
    checks++; if (t_obs != t_end) begin errors++; $display("FAIL retrig_end: got idle at %0d, need %0d", t_obs, t_end); end
    repeat (10) tick();
    checks++; if (busy !== 1'b0 || act_req.size() != N_REGS) begin
      errors++; $display("FAIL retrig_no_extra: got busy %b reqs %0d, need busy 0 reqs %0d", busy, act_req.size(), N_REGS);
    end
  endtask

  task automatic test_reset_mid();
    bit done, found; int t_obs, es, t, t_end, e_err, d, act;
    spur_en = 1'b1;
    for (int i = 0; i < N_REGS; i++) begin lat_r[i] = int'($urandom_range(0, 3)); dat_r[i] = 8'h30 + i; end
    V_ON = 1'b1; tick(); V_ON = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (rd_req === 1'b1 && rd_addr === 8'h25) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach: got no request to 25, need one"); end
    #2 resetM = 1'b1;
    #1;
    checks++;
    if ({rd_req, rd_addr, DIR_DATO, POSICION, RD, busy, err} !== 23'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got req%b addr%h dat%h pos%h rd%b busy%b err%b, need all 0",
               rd_req, rd_addr, DIR_DATO, POSICION, RD, busy, err);
    end
    tick();
    resetM = 1'b0;
    act = 0;
    repeat (20) begin
      tick();
      if (rd_req !== 1'b0 || busy !== 1'b0 || RD !== 1'b0) act++;
    end
    checks++; if (act != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles, need 0", act); end
    drive_sweep(-1, done, t_obs, es, t);
    build_exp(t, t_end, e_err);
    d = rd_diff();
    checks++; if (d >= 0) begin errors++; $display("FAIL rstmid_sweep_rd: %s", rd_str(d)); end
  endtask

  task automatic test_random();
    bit done; int t_obs, es, t, t_end, e_err, d;
    for (int it = 0; it < 4; it++) begin
      spur_en = 1'($urandom_range(0, 1));
      for (int i = 0; i < N_REGS; i++) begin
        lat_r[i] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
        dat_r[i] = int'($urandom_range(0, 255));
      end
      drive_sweep(-1, done, t_obs, es, t);
      build_exp(t, t_end, e_err);
      checks++; if (t_obs != t_end) begin errors++; $display("FAIL rand%0d_end: got idle at %0d, need %0d", it, t_obs, t_end); end
      d = rd_diff();
      checks++; if (d >= 0) begin errors++; $display("FAIL rand%0d_rd: %s", it, rd_str(d)); end
      d = req_diff();
      checks++; if (d >= 0) begin errors++; $display("FAIL rand%0d_req: %s", it, req_str(d)); end
      checks++; if (err !== 1'(e_err)) begin errors++; $display("FAIL rand%0d_err: got %b, need %0d", it, err, e_err); end
    end
  endtask

`ifdef FEEDER_BCD_CHECK_EN
  task automatic test_bcd();
    bit done; int t_obs, es, t, t_end, e_err, d;
    spur_en = 1'b0;
    for (int i = 0; i < N_REGS; i++) begin lat_r[i] = 1; dat_r[i] = 8'h10 + i; end
    dat_r[0] = 8'h5A;
    drive_sweep(-1, done, t_obs, es, t);
    build_exp(t, t_end, e_err);
    d = rd_diff();
    checks++; if (d >= 0) begin errors++; $display("FAIL bcd_rd: %s", rd_str(d)); end
    checks++; if (act_rd.size() > 0 && act_rd[0].pos == 0) begin errors++; $display("FAIL bcd_pos0: got strobe for pos 0, need none"); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bcd_err: got %b, need 1", err); end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, need finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; req_prev = 1'b0; addr_unstable = 0;
    test_reset();
    test_single_sweep();
    test_wait_states();
    test_timeout();
    test_retrigger();
    test_reset_mid();
    test_random();
`ifdef FEEDER_BCD_CHECK_EN
    test_bcd();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_display_feeder.md
# rtc_display_feeder

Refresh sequencer between the RTC bus controller and the VGA top-level. Once per video frame, on entry into vertical blanking, it reads the nine RTC time/date/chronometer registers over a request/acknowledge handshake. Each returned byte is forwarded to the VGA digit renderer as a `DIR_DATO`/`POSICION` pair with a one-cycle `RD` strobe, so digits update only while nothing is being drawn.

## Interface
Parameters:
- `N_REGS`, 9: number of registers swept per frame (1..16).
- `TIMEOUT`, 255: max cycles to wait for `rd_ack` before skipping a register.

Ports:
- `reloj`, in, 1: system clock; the only clock.
- `resetM`, in, 1: asynchronous, active-high reset.
- `V_ON`, in, 1: vertical visible-region flag from the VGA counter. High means drawing.
- `rd_req`, out, 1: read request to the RTC bus controller.
- `rd_addr`, out, 8: RTC register address; stable while `rd_req` is high.
- `rd_ack`, in, 1: read complete; `rd_data` is valid in the same cycle.
- `rd_data`, in, 8: BCD byte returned by the RTC.
- `DIR_DATO`, out, 8: byte delivered to the digit renderer.
- `POSICION`, out, 4: display slot index for `DIR_DATO`.
- `RD`, out, 1: one-cycle strobe; `DIR_DATO`/`POSICION` are valid in that cycle.
- `busy`, out, 1: high while a sweep is in progress.
- `err`, out, 1: summary of the last completed sweep; 1 means at least one register was skipped.

## Operation
- FSM states:
  - **IDLE**: wait for a frame trigger, i.e. `V_ON` registered 1 in the previous cycle and 0 now (falling edge). On trigger: clear index, clear sweep-error flag, go to REQ.
  - **REQ**: drive `rd_req`=1 and `rd_addr`=ADDR_TABLE[idx]; the timeout counter runs.
    - On `rd_ack`=1: capture `rd_data`, go to PUSH.
    - On timeout counter == `TIMEOUT` without ack: set sweep-error flag, go to NEXT.
  - **PUSH**: registered outputs `DIR_DATO`=captured byte, `POSICION`=idx, `RD`=1 for exactly this cycle; go to NEXT.
  - **NEXT**: `rd_req`=0.
    - If idx == `N_REGS`-1: `err` ← sweep-error flag, go to IDLE.
    - Otherwise idx+1, reset timeout counter, go to REQ.
- Address table, with `POSICION` equal to the table index: 0x21 sec, 0x22 min, 0x23 hour, 0x24 day, 0x25 month, 0x26 year, 0x41 crono sec, 0x42 crono min, 0x43 crono hour.
- Handshake rules:
  - `rd_req` stays high until `rd_ack` is sampled or a timeout occurs.
  - `rd_ack` is ignored outside REQ.
  - A late ack that arrives after a timeout is discarded.
- A frame trigger during a sweep (`busy`=1) is ignored and not queued.
- `busy` = (state != IDLE).
- `DIR_DATO` and `POSICION` hold their last values between strobes.
- Timeout counter width: clog2(`TIMEOUT`+1). It saturates and does not wrap.
- Reset, including mid-sweep: every output goes to 0 (`rd_req`, `rd_addr`, `DIR_DATO`, `POSICION`, `RD`, `busy`, `err`), state goes to IDLE, index and counters go to 0. The edge-detect register resets to 0, so no trigger fires on the first cycle after reset.

## Timing
- Trigger seen in cycle t (V_ON=0, previous V_ON=1): `rd_req` is high in cycle t+1.
- Ack sampled in cycle a: `RD` is high in a+1, `rd_req` is low in a+1 and a+2, and the next `rd_req` is high in a+3.
- Minimum cost is 3 cycles per register. A zero-latency RTC therefore needs 27 cycles for 9 registers, well inside vertical blanking.
- Timeout: `rd_req` is high for `TIMEOUT`+1 cycles, then low for one cycle (NEXT), then the next register is requested. No `RD` strobe is issued for the skipped register.
- `err` updates in the NEXT cycle of the final register and holds until the end of the next sweep.

## Configuration
- `FEEDER_BCD_CHECK_EN` defined: a captured byte with either nibble > 9 is not forwarded (PUSH is skipped, no `RD`) and sets the sweep-error flag.
- Macro undefined: every acknowledged byte is forwarded verbatim.

## Structure
- Package `feeder_pkg` holds:
  - the state enum (IDLE, REQ, PUSH, NEXT);
  - the `ADDR_TABLE` constant array of 16×8 bits, unused entries 0x00;
  - the default `N_REGS` and `TIMEOUT`.
- One sub-module, `feeder_timeout`: a saturating counter with `clr`/`en` inputs and an `expired` output. It is shared with other bus masters in the design.

## Test plan
- Single sweep: drive a V_ON 1→0 edge with a zero-wait RTC model returning addr+1. Expect nine `RD` pulses with `POSICION` 0..8 and `DIR_DATO` 0x22,0x23,…,0x44, each 3 cycles apart; then `busy`=0 and `err`=0.
- Wait states: the RTC acks 5 cycles after the request. `rd_req` and `rd_addr` must stay stable the whole time, and `RD` must follow 1 cycle after ack.
- Timeout: the RTC never acks address 0x23. Expect `rd_req` high for 256 cycles, no `RD` for `POSICION`=2, the sweep continuing at 0x24, and `err`=1 after the sweep. A following clean sweep must return `err`=0.
- Retrigger: a second V_ON falling edge mid-sweep produces no extra requests, and the sweep completes normally.
- Reset mid-sweep: assert `resetM` while in REQ at idx 4. All outputs are 0 immediately (asynchronous reset), and there is no activity until the next V_ON edge.
- With `FEEDER_BCD_CHECK_EN`: the RTC returns 0x5A for sec. Expect no `RD` for `POSICION`=0 and `err`=1.
